// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoded ID controls through EX/MEM/WB, detects load-use and
// control hazards, and drives operand forwarding selects. Macro CTRL_PIPE_FORWARDING_EN.
module ctrl_pipe #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               Jump,
  input  logic               Branch,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemtoReg,
  input  logic               RegDst,
  input  logic               RegWrite,
  input  logic               ALUSrc,
  input  logic [ALUOP_W-1:0] AluOp,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               alu_zero,
  output logic               stall,
  output logic               flush,
  output logic               ex_Jump,
  output logic               ex_Branch,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_MemtoReg,
  output logic               ex_RegWrite,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_AluOp,
  output logic [REG_AW-1:0]  ex_wreg,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_MemtoReg,
  output logic               mem_RegWrite,
  output logic [REG_AW-1:0]  mem_wreg,
  output logic               wb_MemtoReg,
  output logic               wb_RegWrite,
  output logic [REG_AW-1:0]  wb_wreg,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic              vld_p1, vld_p2, vld_p3;
  logic [REG_AW-1:0] id_wreg;
  logic              uses_rt;
  logic              load_use;
  logic              raw_hz;
  logic              bubble;

  // Register r is produced by a stage holding a valid, nonzero-destination write.
  function automatic logic wr_match(input logic v, input logic we,
                                    input logic [REG_AW-1:0] wreg,
                                    input logic [REG_AW-1:0] r);
    return v & we & (wreg != '0) & (wreg == r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + {{(CNT_W-1){1'b0}}, 1'b1} : c;
  endfunction

  // ID stage: hazard detection against EX/MEM
  always_comb begin
    id_wreg  = RegDst ? id_rd : id_rt;
    uses_rt  = RegDst | MemWrite | Branch;
    flush    = vld_p1 & (ex_Jump | (ex_Branch & alu_zero));
    load_use = id_valid & ex_MemRead &
               (wr_match(vld_p1, ex_RegWrite, ex_wreg, id_rs) |
                (uses_rt & wr_match(vld_p1, ex_RegWrite, ex_wreg, id_rt)));
`ifdef CTRL_PIPE_FORWARDING_EN
    raw_hz   = 1'b0;
`else
    raw_hz   = id_valid &
               (wr_match(vld_p1, ex_RegWrite, ex_wreg, id_rs) |
                wr_match(vld_p2, mem_RegWrite, mem_wreg, id_rs) |
                (uses_rt & (wr_match(vld_p1, ex_RegWrite, ex_wreg, id_rt) |
                            wr_match(vld_p2, mem_RegWrite, mem_wreg, id_rt))));
`endif
    stall    = (load_use | raw_hz) & ~flush;
    bubble   = flush | stall;
  end

`ifdef CTRL_PIPE_FORWARDING_EN
  logic [REG_AW-1:0] rs_p1, rt_p1;

  // Source registers are cleared with the bubble so an empty EX never forwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_p1 <= '0;
      rt_p1 <= '0;
    end else begin
      rs_p1 <= (bubble || !id_valid) ? '0 : id_rs;
      rt_p1 <= (bubble || !id_valid) ? '0 : id_rt;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (wr_match(vld_p2, mem_RegWrite, mem_wreg, rs_p1))     fwd_a = 2'b10;
    else if (wr_match(vld_p3, wb_RegWrite, wb_wreg, rs_p1))  fwd_a = 2'b01;
    if (wr_match(vld_p2, mem_RegWrite, mem_wreg, rt_p1))     fwd_b = 2'b10;
    else if (wr_match(vld_p3, wb_RegWrite, wb_wreg, rt_p1))  fwd_b = 2'b01;
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // ID -> EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_AluOp    <= '0;
      ex_wreg     <= '0;
    end else if (bubble) begin
      vld_p1      <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_AluOp    <= '0;
      ex_wreg     <= '0;
    end else begin
      vld_p1      <= id_valid;
      ex_Jump     <= Jump & id_valid;
      ex_Branch   <= Branch & id_valid;
      ex_MemRead  <= MemRead & id_valid;
      ex_MemWrite <= MemWrite & id_valid;
      ex_MemtoReg <= MemtoReg & id_valid;
      ex_RegWrite <= RegWrite & id_valid;
      ex_ALUSrc   <= ALUSrc & id_valid;
      ex_AluOp    <= id_valid ? AluOp : '0;
      ex_wreg     <= id_valid ? id_wreg : '0;
    end
  end

  // EX -> MEM -> WB, never stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2       <= 1'b0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_MemtoReg <= 1'b0;
      mem_RegWrite <= 1'b0;
      mem_wreg     <= '0;
      vld_p3       <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_wreg      <= '0;
    end else begin
      vld_p2       <= vld_p1;
      mem_MemRead  <= ex_MemRead & vld_p1;
      mem_MemWrite <= ex_MemWrite & vld_p1;
      mem_MemtoReg <= ex_MemtoReg & vld_p1;
      mem_RegWrite <= ex_RegWrite & vld_p1;
      mem_wreg     <= vld_p1 ? ex_wreg : '0;
      vld_p3       <= vld_p2;
      wb_MemtoReg  <= mem_MemtoReg & vld_p2;
      wb_RegWrite  <= mem_RegWrite & vld_p2;
      wb_wreg      <= vld_p2 ? mem_wreg : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, stall);
      flush_cnt <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus pushes predicted outputs, a negedge monitor compares.
module tb_ctrl_pipe;
  localparam int AW = 5;
  localparam int OW = 6;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, Jump, Branch, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrc;
  logic [OW-1:0] AluOp;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic alu_zero;
  logic stall, flush;
  logic ex_Jump, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite, ex_ALUSrc;
  logic [OW-1:0] ex_AluOp;
  logic [AW-1:0] ex_wreg, mem_wreg, wb_wreg;
  logic mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite, wb_MemtoReg, wb_RegWrite;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic iv, j, b, mr, mw, m2r, rdsel, rw, as;
    logic [OW-1:0] op;
    logic [AW-1:0] rs, rt, rd;
    logic z;
  } in_t;

  typedef struct packed {
    logic v, j, b, mr, mw, m2r, rw, as;
    logic [OW-1:0] op;
    logic [AW-1:0] wreg, rs, rt;
  } stg_t;

  typedef struct packed {
    logic st, fl;
    logic [1:0] fa, fb;
    logic [17:0] ex;
    logic [8:0] mem;
    logic [6:0] wb;
    logic [CW-1:0] sc, fc;
  } exp_t;

  in_t  din;
  stg_t pipe [3];   // [0]=EX [1]=MEM [2]=WB
  int   scnt, fcnt;
  in_t  cur_in;
  exp_t cur_e;
  logic cur_rst;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  assign id_valid = din.iv;
  assign Jump     = din.j;
  assign Branch   = din.b;
  assign MemRead  = din.mr;
  assign MemWrite = din.mw;
  assign MemtoReg = din.m2r;
  assign RegDst   = din.rdsel;
  assign RegWrite = din.rw;
  assign ALUSrc   = din.as;
  assign AluOp    = din.op;
  assign id_rs    = din.rs;
  assign id_rt    = din.rt;
  assign id_rd    = din.rd;
  assign alu_zero = din.z;

  ctrl_pipe #(.REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .AluOp(AluOp), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .alu_zero(alu_zero), .stall(stall), .flush(flush),
    .ex_Jump(ex_Jump), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
    .ex_ALUSrc(ex_ALUSrc), .ex_AluOp(ex_AluOp), .ex_wreg(ex_wreg),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_RegWrite(mem_RegWrite), .mem_wreg(mem_wreg), .wb_MemtoReg(wb_MemtoReg),
    .wb_RegWrite(wb_RegWrite), .wb_wreg(wb_wreg), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic writes(stg_t s, logic [AW-1:0] r);
    return s.v && s.rw && (s.wreg != 0) && (s.wreg == r);
  endfunction

  function automatic logic [1:0] fwd_of(logic [AW-1:0] r);
`ifdef CTRL_PIPE_FORWARDING_EN
    if (pipe[0].v && writes(pipe[1], r)) return 2'b10;
    if (pipe[0].v && writes(pipe[2], r)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic exp_t predict(in_t x);
    exp_t e;
    logic urt, lu, raw;
    urt = x.rdsel || x.mw || x.b;
    e.fl = pipe[0].v && (pipe[0].j || (pipe[0].b && x.z));
    lu = x.iv && pipe[0].mr && (writes(pipe[0], x.rs) || (urt && writes(pipe[0], x.rt)));
    raw = 1'b0;
`ifndef CTRL_PIPE_FORWARDING_EN
    raw = x.iv && (writes(pipe[0], x.rs) || writes(pipe[1], x.rs) ||
                   (urt && (writes(pipe[0], x.rt) || writes(pipe[1], x.rt))));
`endif
    e.st  = (lu || raw) && !e.fl;
    e.fa  = fwd_of(pipe[0].rs);
    e.fb  = fwd_of(pipe[0].rt);
    e.ex  = {pipe[0].j, pipe[0].b, pipe[0].mr, pipe[0].mw, pipe[0].m2r, pipe[0].rw,
             pipe[0].as, pipe[0].op, pipe[0].wreg};
    e.mem = {pipe[1].mr, pipe[1].mw, pipe[1].m2r, pipe[1].rw, pipe[1].wreg};
    e.wb  = {pipe[2].m2r, pipe[2].rw, pipe[2].wreg};
    e.sc  = CW'(scnt);
    e.fc  = CW'(fcnt);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    scnt = 0;
    fcnt = 0;
  endtask

  task automatic model_step(in_t x, exp_t e);
    stg_t n;
    if (e.st && scnt < (1 << CW) - 1) scnt++;
    if (e.fl && fcnt < (1 << CW) - 1) fcnt++;
    n = '0;
    if (x.iv && !e.st && !e.fl) begin
      n.v = 1'b1; n.j = x.j; n.b = x.b; n.mr = x.mr; n.mw = x.mw; n.m2r = x.m2r;
      n.rw = x.rw; n.as = x.as; n.op = x.op; n.wreg = x.rdsel ? x.rd : x.rt;
      n.rs = x.rs; n.rt = x.rt;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = n;
  endtask

  task automatic cycle(input logic r, input in_t x, output logic st);
    @(posedge clk);
    if (!cur_rst) model_step(cur_in, cur_e);
    #1;
    din = x;
    rst = r;
    cur_in = x;
    cur_rst = r;
    if (r) model_reset();
    cur_e = predict(x);
    q.push_back(cur_e);
    st = cur_e.st;
  endtask

  task automatic issue(in_t x);
    logic st;
    int n;
    n = 0;
    do begin
      cycle(1'b0, x, st);
      n++;
    end while (st && n < 8);
    if (st) begin
      total++;
      bad++;
      $display("FAIL stall_bound: stall still high after %0d cycles, required release", n);
    end
  endtask

  function automatic in_t mk(logic j, logic b, logic mr, logic mw, logic m2r, logic rdsel,
                             logic rw, logic as, int rs, int rt, int rd, logic z);
    in_t x;
    x.iv = 1'b1; x.j = j; x.b = b; x.mr = mr; x.mw = mw; x.m2r = m2r; x.rdsel = rdsel;
    x.rw = rw; x.as = as; x.op = OW'($urandom);
    x.rs = AW'(rs); x.rt = AW'(rt); x.rd = AW'(rd); x.z = z;
    return x;
  endfunction

  function automatic in_t rnd_instr();
    in_t x;
    x = in_t'({$urandom, $urandom});
    x.iv = ($urandom_range(0, 9) < 8);
    x.j  = ($urandom_range(0, 15) == 0);
    x.b  = ($urandom_range(0, 7) == 0);
    x.rs = AW'($urandom_range(0, 3));
    x.rt = AW'($urandom_range(0, 3));
    x.rd = AW'($urandom_range(0, 3));
    return x;
  endfunction

  function automatic in_t nop();
    in_t x;
    x = '0;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 32'(stall), 32'(e.st));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("fwd_a", 32'(fwd_a), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b), 32'(e.fb));
        chk("ex_bundle", 32'({ex_Jump, ex_Branch, ex_MemRead, ex_MemWrite, ex_MemtoReg,
                              ex_RegWrite, ex_ALUSrc, ex_AluOp, ex_wreg}), 32'(e.ex));
        chk("mem_bundle", 32'({mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_RegWrite,
                               mem_wreg}), 32'(e.mem));
        chk("wb_bundle", 32'({wb_MemtoReg, wb_RegWrite, wb_wreg}), 32'(e.wb));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  initial begin : stim
    logic st;
    rst = 1'b1;
    din = '0;
    cur_in = '0;
    cur_rst = 1'b1;
    model_reset();
    cur_e = predict(cur_in);

    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_instr(), st);
    for (int i = 0; i < 3; i++) begin
      in_t x;
      x = rnd_instr();
      x.iv = 1'b0;
      cycle(1'b0, x, st);
    end

    // add r3 then reader of r3
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 3, 0));
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 3, 4, 6, 0));
    repeat (4) issue(nop());

    // lw r5 then add using r5
    issue(mk(0, 0, 1, 0, 1, 0, 1, 1, 1, 5, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 5, 2, 7, 0));
    repeat (4) issue(nop());

    // taken and not-taken branch
    issue(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 4, 1));
    issue(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 4, 0));
    repeat (4) issue(nop());

    // load-use colliding with a jump in EX
    issue(mk(1, 0, 1, 0, 1, 0, 1, 0, 1, 7, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 7, 7, 2, 0));
    repeat (4) issue(nop());

    // writes to r0 followed by a reader of r0
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 0));
    issue(mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0));
    issue(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 5, 0));
    repeat (4) issue(nop());

    // drive stall_cnt into saturation
    repeat (300) issue(mk(0, 0, 1, 0, 1, 0, 1, 1, 5, 5, 0, 0));
    repeat (4) issue(nop());

    // reset while instructions are in flight
    repeat (20) issue(rnd_instr());
    cycle(1'b1, rnd_instr(), st);
    cycle(1'b1, rnd_instr(), st);

    repeat (1500) issue(rnd_instr());
    repeat (4) issue(nop());

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
